// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg: shared register/word types and the forwarding-stage record
// used by the decode-stage operand resolver and its scoreboard.
package fwd_scoreboard_pkg;
    localparam int NREG = 32;
    localparam int XLEN = 64;
    localparam int AW   = $clog2(NREG);
    typedef logic [AW-1:0]   creg_addr_t;
    typedef logic [XLEN-1:0] word_t;
    typedef struct packed {
        logic       valid;
        creg_addr_t dst;
        word_t      data;
        logic       notready;
    } fwd_stage_t;
endpackage

// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: operand, forwarding, issue and status signals of the decode scoreboard.
interface fwd_scoreboard_if
    import fwd_scoreboard_pkg::*;
#(
    parameter int NRD  = 2,
    parameter int NFWD = 3,
    parameter int LATW = 6
);
    creg_addr_t        ra           [NRD];
    word_t             rd           [NRD];
    logic              fwd_valid    [NFWD];
    creg_addr_t        fwd_dst      [NFWD];
    word_t             fwd_data     [NFWD];
    logic              fwd_notready [NFWD];
    logic              issue_valid;
    creg_addr_t        issue_dst;
    logic              issue_multi;
    logic [LATW-1:0]   issue_lat;
    logic              flush;
    word_t             result       [NRD];
    logic              stall;
    logic [NREG-1:0]   busy_vec;
    logic [31:0]       stall_cnt;
    modport master (
        output ra, rd, fwd_valid, fwd_dst, fwd_data, fwd_notready,
               issue_valid, issue_dst, issue_multi, issue_lat, flush,
        input  result, stall, busy_vec, stall_cnt
    );
    modport slave (
        input  ra, rd, fwd_valid, fwd_dst, fwd_data, fwd_notready,
               issue_valid, issue_dst, issue_multi, issue_lat, flush,
        output result, stall, busy_vec, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard_select.sv
// fwd_select: per-port priority mux choosing the youngest matching forwarding stage over regfile data.
module fwd_select
    import fwd_scoreboard_pkg::*;
#(
    parameter int NFWD = 3
) (
    input  creg_addr_t ra,
    input  word_t      rd,
    input  fwd_stage_t fwd [NFWD],
    output word_t      result,
    output logic       stall
);
    // Scan oldest to youngest so the youngest match is the final assignment.
    always_comb begin
        result = rd;
        stall  = 1'b0;
        for (int s = NFWD - 1; s >= 0; s--) begin
            if (ra != '0 && fwd[s].valid && fwd[s].dst == ra) begin
                result = fwd[s].data;
                stall  = fwd[s].notready;
            end
        end
    end
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: decode operand resolution with forwarding plus a pending-write
// scoreboard for multicycle units, WAW protection, flush and a stall counter.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int NRD  = 2,
    parameter int NFWD = 3,
    parameter int LATW = 6
) (
    input logic             clk,
    input logic             resetn,
    fwd_scoreboard_if.slave bus
);
    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [NREG-1:0] busy;
    logic [NRD-1:0]  sel_stall, port_stall;
    fwd_stage_t      stg [NFWD];
    word_t           res [NRD];
    logic            waw, stall, accept;

    always_comb begin
        for (int s = 0; s < NFWD; s++)
            stg[s] = '{valid: bus.fwd_valid[s], dst: bus.fwd_dst[s],
                       data: bus.fwd_data[s], notready: bus.fwd_notready[s]};
    end

    genvar i;
    for (i = 0; i < NRD; i++) begin : g_port
        fwd_select #(.NFWD(NFWD)) u_sel (
            .ra(bus.ra[i]), .rd(bus.rd[i]), .fwd(stg),
            .result(res[i]), .stall(sel_stall[i])
        );
        assign port_stall[i] = sel_stall[i] | busy[bus.ra[i]];
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) busy[r] = cnt_q[r] != '0;
        waw    = bus.issue_valid && bus.issue_dst != '0 && busy[bus.issue_dst];
        stall  = (|port_stall) || waw;
        accept = bus.issue_valid && !stall && !bus.flush;
        // An accepted multicycle issue takes precedence over the countdown of its own register.
        for (int r = 0; r < NREG; r++)
            cnt_d[r] = bus.flush ? '0 :
                       (accept && bus.issue_multi && r != 0 && bus.issue_dst == creg_addr_t'(r)
                        && bus.issue_lat != '0) ? bus.issue_lat :
                       busy[r] ? cnt_q[r] - 1'b1 : cnt_q[r];
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.result    = res;
    assign bus.stall     = stall;
    assign bus.busy_vec  = busy;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the decode-stage operand select: resolves NRD source operands per cycle against NFWD downstream forwarding stages.
- Adds a per-register pending-write scoreboard for multicycle units (mul/div), with countdown counters, WAW protection, flush, and a saturating stall performance counter.
- Sits in decode between regfile read and the decode/execute pipeline register; its stall output gates the fetch/decode enables.

Parameters:
- NREG, 32, architectural register count; register 0 is hardwired zero.
- XLEN, 64, data width.
- NRD, 2, number of source-operand read ports.
- NFWD, 3, number of forwarding stages; index 0 is youngest (execute), NFWD-1 oldest (writeback).
- LATW, 6, width of the per-register latency counter.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- ra[NRD]  in  $clog2(NREG)  source register addresses
- rd[NRD]  in  XLEN  regfile read data
- fwd_valid[NFWD]  in  1  stage holds a register-writing instruction
- fwd_dst[NFWD]  in  $clog2(NREG)  stage destination register
- fwd_data[NFWD]  in  XLEN  stage result
- fwd_notready[NFWD]  in  1  stage result not yet produced (load in flight)
- issue_valid  in  1  decode instruction presented for issue
- issue_dst  in  $clog2(NREG)  its destination register
- issue_multi  in  1  destination written by a multicycle unit
- issue_lat  in  LATW  cycles until the multicycle result reaches stage NFWD-1
- flush  in  1  pipeline flush
- result[NRD]  out  XLEN  resolved operands
- stall  out  1  hold decode this cycle
- busy_vec  out  NREG  scoreboard-pending mask
- stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- State: cnt[NREG] of LATW bits; stall_cnt of 32 bits. Async reset clears both to 0. Every output is combinational from state and inputs. With no activity, after reset: result=rd, stall=0, busy_vec=0, stall_cnt=0.
- Operand resolution, per port i, combinational:
  - ra==0 -> result=rd, port never stalls.
  - Otherwise scan stages 0..NFWD-1; the first s with fwd_valid[s] and fwd_dst[s]==ra wins.
  - fwd_notready[s]=1 on the winning stage -> port stalls.
  - Else result=fwd_data[s].
  - No matching stage -> result=rd.
  - cnt[ra]!=0 -> port stalls, regardless of any forwarding match.
- Issue hazard: issue_valid and issue_dst!=0 and cnt[issue_dst]!=0 -> stall (WAW).
- stall = OR of all port stalls OR the WAW hazard.
- Accepted issue = issue_valid and !stall and !flush.
- Counter update, per register, at each clk edge, in priority order:
  1. flush -> 0.
  2. Accepted issue with issue_multi, issue_dst==r, r!=0, issue_lat!=0 -> issue_lat (issue beats decrement).
  3. cnt!=0 -> cnt-1.
  4. Otherwise hold.
- issue_lat==0 creates no entry. cnt[0] is always 0. busy_vec[r] = (cnt[r]!=0).
- A counter reaching 0 releases its register the following cycle. The value is then taken from the forwarding stages or rd.
- stall_cnt increments each cycle stall=1 and saturates at 0xFFFF_FFFF. It is not cleared by flush.
- Reset asserted mid-operation clears all pending entries immediately (asynchronous).

Decomposition:
- Shared pipes package: creg_addr_t, word_t, and the fwd_stage_t struct {valid, dst, data, notready}, carried as an NFWD array. Port shapes stay as listed.
- Shared common package: NREG, XLEN constants.
- Natural sub-module: fwd_select, the per-port combinational priority mux. It takes ra, rd and the stage array and returns result and a port stall. It is instantiated NRD times.
- Scoreboard counters, issue logic and stall_cnt stay in fwd_scoreboard.

Test Plan:
1. Reset, then ra[0]=5, rd[0]=0x11, no stage valid -> result[0]=0x11, stall=0, stall_cnt=0.
2. Stage 0 and stage 2 both valid with dst=5, data 0xAA and 0xCC; ra[0]=5 -> result[0]=0xAA. Set fwd_notready[0]=1 -> stall=1. With ra[0]=0 and the same stages -> result[0]=rd[0], stall=0.
3. Issue multi dst=7, lat=3, no stall. Then ra[1]=7:
   - stall=1 for 3 cycles; busy_vec[7] goes 1,1,1 then 0.
   - 4th cycle: stall=0, result[1] comes from stage NFWD-1 data.
   - stall_cnt=3.
4. While cnt[7]!=0, issue_valid with issue_dst=7 and no read of 7 -> stall=1 (WAW), counter keeps decrementing, no reload.
5. Issue multi dst=9, lat=20; assert flush 2 cycles later -> busy_vec=0 next cycle, stall deasserts for ra=9. Repeat with resetn pulsed low mid-count -> busy_vec=0 asynchronously.
6. Force stall_cnt to 0xFFFF_FFFE, stall 3 cycles -> stall_cnt holds at 0xFFFF_FFFF. Issue multi with dst=0 or lat=0 -> busy_vec stays 0.
